// File: rtl/io_tx_buffer.sv
// io_tx_buffer: CPU memory-mapped byte FIFO feeding a UART transmitter.
// Data writes to 0x30000, stop writes to 0x30004; see header for ports.
//
// Ports:
//   clk_in          system clock, rising edge
//   rst_in          synchronous active-low reset
//   mem_a/mem_dout  CPU address and write byte
//   mem_wr          CPU write strobe
//   tx_data/valid   head byte offered to the UART
//   tx_ready        UART accepts the head byte this cycle
//   io_buffer_full  backpressure, MARGIN entries early
//   overflow        sticky: a push was dropped
//   halted          stop seen and FIFO fully drained
//   count           FIFO occupancy
module io_tx_buffer #(
  parameter int DEPTH  = 16,
  parameter int MARGIN = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [31:0]              mem_a,
  input  logic [7:0]               mem_dout,
  input  logic                     mem_wr,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     io_buffer_full,
  output logic                     overflow,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    buf_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  logic          stop_seen;
  logic          overflow_q;

  logic          io_wr;
  logic          data_req;
  logic          stop_req;
  logic          push_req;
  logic [7:0]    push_byte;
  logic          pop;
  logic          at_depth;
  logic          push_ok;
  logic          drop;

  logic          unused;
  assign unused = ^{mem_a[31:18], mem_a[15:3]};

  // IO writes are ignored entirely once the stop terminator was seen.
  assign io_wr    = mem_wr && (mem_a[17:16] == 2'b11)
                    && !stop_seen;
  assign data_req = io_wr && (mem_a[2:0] == 3'b000)
                    && (mem_dout != 8'h00);
  assign stop_req = io_wr && (mem_a[2:0] == 3'b100);
  assign push_req = data_req || stop_req;

  always_comb begin
    push_byte = 8'h00;
    unique case (1'b1)
      stop_req: push_byte = 8'h00;
      data_req: push_byte = mem_dout;
      default:  push_byte = 8'h00;
    endcase
  end

  assign tx_valid = (count_q != '0);
  assign tx_data  = buf_mem[head];
  assign pop      = tx_valid && tx_ready;

  // A full FIFO still takes a byte if the head leaves on the same edge.
  assign at_depth = (count_q == CW'(DEPTH));
  assign push_ok  = push_req && (!at_depth || pop);
  assign drop     = push_req && !push_ok;

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      buf_mem[tail] <= push_byte;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      stop_seen  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      unique case (1'b1)
        (push_ok && !pop): count_q <= count_q + CW'(1);
        (pop && !push_ok): count_q <= count_q - CW'(1);
        default:           count_q <= count_q;
      endcase
      // A dropped stop still terminates the stream.
      if (stop_req) begin
        stop_seen <= 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // No pushes follow stop, so an empty FIFO after stop stays empty.
  assign halted         = stop_seen && (count_q == '0);
  assign io_buffer_full = (count_q >= CW'(DEPTH - MARGIN));
  assign overflow       = overflow_q;
  assign count          = count_q;

endmodule

// File: tb/tb_io_tx_buffer.sv
// tb_io_tx_buffer: directed and random checks of io_tx_buffer
// against a queue-based reference model.
module tb_io_tx_buffer;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        io_buffer_full;
  logic        overflow;
  logic        halted;
  logic [4:0]  count;

  always #5 clk_in = ~clk_in;

  io_tx_buffer #(.DEPTH(DEPTH), .MARGIN(MARGIN)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .io_buffer_full (io_buffer_full),
    .overflow       (overflow),
    .halted         (halted),
    .count          (count)
  );

  logic [7:0] mq[$];
  logic [7:0] outq[$];
  bit         m_stop;
  bit         m_ovf;
  int         vectors;
  int         miscompares;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".valid"}, 32'(tx_valid), 32'(n != 0));
    chk({tag, ".full"}, 32'(io_buffer_full),
        32'(n >= DEPTH - MARGIN));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".halted"}, 32'(halted), 32'(m_stop && n == 0));
  endtask

  task automatic step(input logic [31:0] a, input logic [7:0] d,
                      input logic wr, input logic rdy,
                      input string tag);
    bit io, dp, sp, pb, acc;
    rst_in   = 1'b1;
    mem_a    = a;
    mem_dout = d;
    mem_wr   = wr;
    tx_ready = rdy;
    #1;
    if (mq.size() != 0) chk({tag, ".data"}, 32'(tx_data), 32'(mq[0]));
    io  = wr && a[17:16] == 2'b11 && !m_stop;
    dp  = io && a[2:0] == 3'd0 && d != 8'h00;
    sp  = io && a[2:0] == 3'd4;
    pb  = mq.size() != 0 && rdy;
    acc = mq.size() < DEPTH || pb;
    if (pb) begin
      outq.push_back(tx_data);
      void'(mq.pop_front());
    end
    if (dp || sp) begin
      if (acc) mq.push_back(sp ? 8'h00 : d);
      else m_ovf = 1'b1;
    end
    if (sp) m_stop = 1'b1;
    @(posedge clk_in);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_in   = 1'b0;
    mem_a    = 32'h30000;
    mem_dout = 8'h55;
    mem_wr   = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk_in);
    #1;
    mq.delete();
    m_stop = 1'b0;
    m_ovf  = 1'b0;
    check_outputs(tag);
    outq.delete();
  endtask

  task automatic idle(input int n, input logic rdy, input string tag);
    for (int i = 0; i < n; i++) step(32'h0, 8'h0, 1'b0, rdy, tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_stop      = 1'b0;
    m_ovf       = 1'b0;
    rst_in      = 1'b0;
    mem_a       = '0;
    mem_dout    = '0;
    mem_wr      = 1'b0;
    tx_ready    = 1'b0;
    @(posedge clk_in);
    #1;
    do_reset("reset");
    do_reset("reset2");

    step(32'h30000, 8'h41, 1'b1, 1'b1, "basic_push");
    chk("basic_valid", 32'(tx_valid), 32'd1);
    chk("basic_data", 32'(tx_data), 32'h41);
    idle(1, 1'b1, "basic_pop");
    chk("basic_empty", 32'(count), 32'd0);
    chk("basic_out", 32'(outq.size() == 1 && outq[0] == 8'h41), 32'd1);

    step(32'h30000, 8'h00, 1'b1, 1'b1, "filt_zero");
    step(32'h00010, 8'h55, 1'b1, 1'b1, "filt_nonio");
    step(32'h30008, 8'h66, 1'b1, 1'b1, "filt_offs");
    step(32'h30000, 8'h77, 1'b0, 1'b1, "filt_read");
    chk("filt_count", 32'(count), 32'd0);

    do_reset("bp_reset");
    for (int i = 0; i < 14; i++) begin
      chk("bp_notfull", 32'(io_buffer_full), 32'd0);
      step(32'h30000, 8'(i + 1), 1'b1, 1'b0, "bp_fill");
    end
    chk("bp_full14", 32'(io_buffer_full), 32'd1);
    step(32'h30000, 8'd15, 1'b1, 1'b0, "bp_fill15");
    step(32'h30000, 8'd16, 1'b1, 1'b0, "bp_fill16");
    chk("bp_cnt16", 32'(count), 32'd16);
    chk("bp_noovf", 32'(overflow), 32'd0);
    step(32'h30000, 8'hEE, 1'b1, 1'b0, "bp_push17");
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_cnt17", 32'(count), 32'd16);
    idle(18, 1'b1, "bp_drain");
    chk("bp_outn", 32'(outq.size()), 32'd16);
    for (int i = 0; i < 16 && i < outq.size(); i++)
      chk("bp_order", 32'(outq[i]), 32'(i + 1));

    do_reset("cp_reset");
    for (int i = 0; i < 16; i++)
      step(32'h30000, 8'(8'h80 + i), 1'b1, 1'b0, "cp_fill");
    step(32'h30000, 8'h7A, 1'b1, 1'b1, "cp_pushpop");
    chk("cp_cnt", 32'(count), 32'd16);
    chk("cp_noovf", 32'(overflow), 32'd0);
    idle(17, 1'b1, "cp_drain");
    chk("cp_outn", 32'(outq.size()), 32'd17);
    if (outq.size() == 17) chk("cp_last", 32'(outq[16]), 32'h7A);
    else chk("cp_last_missing", 32'(outq.size()), 32'd17);

    do_reset("stop_reset");
    step(32'h30000, 8'h4F, 1'b1, 1'b0, "stop_o");
    step(32'h30000, 8'h4B, 1'b1, 1'b0, "stop_k");
    step(32'h30004, 8'h99, 1'b1, 1'b0, "stop_wr");
    step(32'h30000, 8'h58, 1'b1, 1'b0, "stop_x");
    chk("stop_cnt", 32'(count), 32'd3);
    idle(2, 1'b1, "stop_drain");
    chk("stop_nohalt", 32'(halted), 32'd0);
    idle(1, 1'b1, "stop_term");
    chk("stop_halted", 32'(halted), 32'd1);
    idle(2, 1'b1, "stop_hold");
    chk("stop_outn", 32'(outq.size()), 32'd3);
    if (outq.size() == 3)
      chk("stop_seq", {8'h0, outq[0], outq[1], outq[2]},
          32'h004F4B00);

    do_reset("sdrop_reset");
    for (int i = 0; i < 16; i++)
      step(32'h30000, 8'h20, 1'b1, 1'b0, "sdrop_fill");
    step(32'h30004, 8'h00, 1'b1, 1'b0, "sdrop_stop");
    chk("sdrop_ovf", 32'(overflow), 32'd1);
    idle(16, 1'b1, "sdrop_drain");
    chk("sdrop_halted", 32'(halted), 32'd1);

    do_reset("mid_reset");
    for (int i = 0; i < 5; i++)
      step(32'h30000, 8'hA0, 1'b1, 1'b0, "mid_fill");
    step(32'h30000, 8'hEE, 1'b1, 1'b0, "mid_more");
    do_reset("mid_rst");
    chk("mid_cnt", 32'(count), 32'd0);
    chk("mid_valid", 32'(tx_valid), 32'd0);
    idle(2, 1'b1, "mid_quiet");
    step(32'h30000, 8'h31, 1'b1, 1'b0, "mid_push");
    idle(1, 1'b1, "mid_pop");
    chk("mid_first", 32'(outq.size() == 1 && outq[0] == 8'h31), 32'd1);

    do_reset("rnd_reset");
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [7:0]  d;
      int          sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 70)      a = 32'h30000;
      else if (sel < 72) a = 32'h30004;
      else if (sel < 80) a = 32'h00010;
      else if (sel < 90) a = 32'h30008 | 32'($urandom_range(0, 3));
      else               a = $urandom;
      d = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      if (i % 150 == 149) do_reset("rnd_rst");
      else step(a, d, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
